// File: rtl/epmp_call_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : epmp_call_ctrl
// Purpose  : Program-counter and call/return sequencer for the EPMP core.
//            This block is the only source of Push_Stack and Pop_Stack for the
//            external hardware return stack. During a push it drives the
//            return address onto the internal bus. During a pop it reloads
//            the PC from the bus. It also tracks stack occupancy, keeps
//            sticky overflow/underflow flags, and sequences interrupt entry
//            and exit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, all state on rising edge
//   Reset        in   asynchronous active-high reset
//   PC_Inc       in   PC <= PC+1 (IDLE only)
//   Jump         in   PC <= Target (IDLE only)
//   Call         in   push PC+1, then PC <= Target
//   Ret          in   pop return address into PC
//   Reti         in   as Ret, and clears Int_Active
//   Irq          in   level interrupt request
//   Target[15:0] in   jump/call destination
//   IBH/IBL[7:0] io   internal bus, driven only while pushing
//   Push_Stack   out  stack push strobe (PUSH state)
//   Pop_Stack    out  stack pop strobe (POP state)
//   PC[15:0]     out  program counter
//   Busy         out  PUSH or POP in progress
//   Depth[2:0]   out  stack occupancy, saturating at STACK_DEPTH
//   Overflow     out  sticky, push onto a full stack
//   Underflow    out  sticky, pop from an empty stack
//   Int_Active   out  interrupt service in progress
// ============================================================================
module epmp_call_ctrl #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0004,
  parameter int unsigned STACK_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        PC_Inc,
  input  logic        Jump,
  input  logic        Call,
  input  logic        Ret,
  input  logic        Reti,
  input  logic        Irq,
  input  logic [15:0] Target,
  inout  wire  [7:0]  IBH,
  inout  wire  [7:0]  IBL,
  output logic        Push_Stack,
  output logic        Pop_Stack,
  output logic [15:0] PC,
  output logic        Busy,
  output logic [2:0]  Depth,
  output logic        Overflow,
  output logic        Underflow,
  output logic        Int_Active
);

  localparam logic [2:0] c_DEPTH_MAX = 3'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_POP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_pc;
  logic [15:0] r_ret_addr;
  logic [15:0] r_target;
  logic [2:0]  r_depth;
  logic        r_ovf;
  logic        r_udf;
  logic        r_int_active;
  logic        r_reti_pend;

  logic        w_take_irq;
  logic        w_take_call;
  logic        w_take_ret;
  logic        w_take_reti;
  logic        w_take_jump;
  logic        w_take_inc;
  logic        w_push;
  logic        w_pop;
  logic [15:0] w_pc_inc;
  logic [15:0] w_bus_in;

  assign w_pc_inc = r_pc + 16'd1;
  assign w_bus_in = {IBH, IBL};

  // ------------------------------------------------------------------------
  // Next-state and command decode. At most one command is accepted per IDLE
  // cycle. Irq is masked while an interrupt is already being serviced, so a
  // held request falls through to the lower-priority commands.
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_take_irq  = 1'b0;
    w_take_call = 1'b0;
    w_take_ret  = 1'b0;
    w_take_reti = 1'b0;
    w_take_jump = 1'b0;
    w_take_inc  = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Irq && !r_int_active) begin
          w_take_irq  = 1'b1;
          w_state_nxt = S_PUSH;
        end else if (Call) begin
          w_take_call = 1'b1;
          w_state_nxt = S_PUSH;
        end else if (Reti) begin
          w_take_reti = 1'b1;
          w_state_nxt = S_POP;
        end else if (Ret) begin
          w_take_ret  = 1'b1;
          w_state_nxt = S_POP;
        end else if (Jump) begin
          w_take_jump = 1'b1;
        end else if (PC_Inc) begin
          w_take_inc  = 1'b1;
        end
      end
      S_PUSH: begin
        w_push      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_POP: begin
        w_pop       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ------------------------------------------------------------------------
  // Datapath. The accept branches and the PUSH/POP branches are mutually
  // exclusive because they are decoded from different states.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_pc         <= RESET_VECTOR;
      r_ret_addr   <= 16'h0000;
      r_target     <= 16'h0000;
      r_depth      <= 3'd0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_int_active <= 1'b0;
      r_reti_pend  <= 1'b0;
    end else begin
      if (w_take_irq) begin
        // The interrupted instruction has not executed yet, so the return
        // point is the current PC rather than PC+1.
        r_ret_addr   <= r_pc;
        r_target     <= IRQ_VECTOR;
        r_int_active <= 1'b1;
      end
      if (w_take_call) begin
        r_ret_addr <= w_pc_inc;
        r_target   <= Target;
      end
      if (w_take_reti) r_reti_pend <= 1'b1;
      if (w_take_ret)  r_reti_pend <= 1'b0;
      if (w_take_jump) r_pc <= Target;
      if (w_take_inc)  r_pc <= w_pc_inc;

      if (w_push) begin
        r_pc <= r_target;
        // A push onto a full stack still happens (the oldest entry is lost);
        // only the occupancy count saturates.
        if (r_depth >= c_DEPTH_MAX) begin
          r_depth <= c_DEPTH_MAX;
          r_ovf   <= 1'b1;
        end else begin
          r_depth <= r_depth + 3'd1;
        end
      end

      if (w_pop) begin
        // The stack presents its top entry during POP and shifts on this
        // same edge, so the bus is captured here.
        r_pc <= w_bus_in;
        if (r_depth == 3'd0) r_udf <= 1'b1;
        else                 r_depth <= r_depth - 3'd1;
        if (r_reti_pend) begin
          r_int_active <= 1'b0;
          r_reti_pend  <= 1'b0;
        end
      end
    end
  end

  // Strobes, Busy and the bus enable decode the state register directly so
  // that an asynchronous reset drops them in the same instant.
  assign Push_Stack = (r_state == S_PUSH);
  assign Pop_Stack  = (r_state == S_POP);
  assign Busy       = Push_Stack | Pop_Stack;

  assign IBH = Push_Stack ? r_ret_addr[15:8] : 8'bzzzz_zzzz;
  assign IBL = Push_Stack ? r_ret_addr[7:0]  : 8'bzzzz_zzzz;

  assign PC         = r_pc;
  assign Depth      = r_depth;
  assign Overflow   = r_ovf;
  assign Underflow  = r_udf;
  assign Int_Active = r_int_active;

endmodule
`default_nettype wire

// File: tb/tb_epmp_call_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_epmp_call_ctrl
// Purpose  : Directed self-checking bench for epmp_call_ctrl. A small
//            4-entry return stack model answers the push/pop strobes. IBH is
//            pulled low and IBL pulled high, so an undriven bus reads 16'h00FF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_epmp_call_ctrl;

  logic        clk;
  logic        Reset;
  logic        PC_Inc, Jump, Call, Ret, Reti, Irq;
  logic [15:0] Target;
  tri0  [7:0]  IBH;
  tri1  [7:0]  IBL;
  logic        Push_Stack, Pop_Stack, Busy;
  logic [15:0] PC;
  logic [2:0]  Depth;
  logic        Overflow, Underflow, Int_Active;

  wire  [15:0] w_bus = {IBH, IBL};
  localparam logic [15:0] c_BUS_IDLE = 16'h00FF;

  int n_tests = 0;
  int n_fail  = 0;

  epmp_call_ctrl dut (
    .clk        (clk),
    .Reset      (Reset),
    .PC_Inc     (PC_Inc),
    .Jump       (Jump),
    .Call       (Call),
    .Ret        (Ret),
    .Reti       (Reti),
    .Irq        (Irq),
    .Target     (Target),
    .IBH        (IBH),
    .IBL        (IBL),
    .Push_Stack (Push_Stack),
    .Pop_Stack  (Pop_Stack),
    .PC         (PC),
    .Busy       (Busy),
    .Depth      (Depth),
    .Overflow   (Overflow),
    .Underflow  (Underflow),
    .Int_Active (Int_Active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Return stack model: top in s0, zeros shift in from the bottom on pop.
  logic [15:0] s0 = 16'h0, s1 = 16'h0, s2 = 16'h0, s3 = 16'h0;
  always @(posedge clk) begin
    if (Push_Stack) begin
      s3 <= s2; s2 <= s1; s1 <= s0; s0 <= w_bus;
    end else if (Pop_Stack) begin
      s0 <= s1; s1 <= s2; s2 <= s3; s3 <= 16'h0;
    end
  end
  assign IBH = Pop_Stack ? s0[15:8] : 8'bzzzz_zzzz;
  assign IBL = Pop_Stack ? s0[7:0]  : 8'bzzzz_zzzz;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_pc(input logic [15:0] v);
    Jump = 1'b1; Target = v;
    tick;
    Jump = 1'b0;
  endtask

  logic [15:0] call_tgt [5];
  logic [15:0] call_bus [5];
  logic [15:0] ret_pc   [5];

  initial begin
    call_tgt[0] = 16'h0100; call_tgt[1] = 16'h0200; call_tgt[2] = 16'h0300;
    call_tgt[3] = 16'h0400; call_tgt[4] = 16'h0500;
    call_bus[0] = 16'h0012; call_bus[1] = 16'h0101; call_bus[2] = 16'h0201;
    call_bus[3] = 16'h0301; call_bus[4] = 16'h0401;
    ret_pc[0]   = 16'h0401; ret_pc[1]   = 16'h0301; ret_pc[2]   = 16'h0201;
    ret_pc[3]   = 16'h0101; ret_pc[4]   = 16'h0000;

    Reset = 1'b1;
    PC_Inc = 1'b0; Jump = 1'b0; Call = 1'b0; Ret = 1'b0; Reti = 1'b0; Irq = 1'b0;
    Target = 16'h0000;

    // Reset state, before any clock edge.
    #1;
    chk("rst_pc",    PC,                 16'h0000);
    chk("rst_depth", 16'(Depth),         16'h0000);
    chk("rst_strb",  16'({Push_Stack, Pop_Stack, Busy}), 16'h0000);
    chk("rst_flags", 16'({Overflow, Underflow, Int_Active}), 16'h0000);
    chk("rst_bus",   w_bus,              c_BUS_IDLE);
    tick;
    Reset = 1'b0;
    tick;

    // Reset applied in the middle of a POP.
    set_pc(16'h1234);
    chk("jump_pc", PC, 16'h1234);
    Ret = 1'b1;
    tick;
    Ret = 1'b0;
    chk("midpop_pop", 16'(Pop_Stack), 16'h0001);
    chk("midpop_busy", 16'(Busy), 16'h0001);
    Reset = 1'b1;
    #1;
    chk("arst_pc",    PC, 16'h0000);
    chk("arst_depth", 16'(Depth), 16'h0000);
    chk("arst_strb",  16'({Push_Stack, Pop_Stack, Busy}), 16'h0000);
    chk("arst_bus",   w_bus, c_BUS_IDLE);
    Reset = 1'b0;
    tick;
    chk("arst_pc2",  PC, 16'h0000);
    chk("arst_udf",  16'(Underflow), 16'h0000);

    // Basic call / return.
    set_pc(16'h0010);
    Call = 1'b1; Target = 16'h0200;
    tick;
    Call = 1'b0;
    chk("call_push", 16'({Push_Stack, Pop_Stack, Busy}), 16'h0005);
    chk("call_bus",  w_bus, 16'h0011);
    chk("call_pc_hold", PC, 16'h0010);
    tick;
    chk("call_pc",    PC, 16'h0200);
    chk("call_depth", 16'(Depth), 16'h0001);
    chk("call_idle",  16'({Push_Stack, Busy}), 16'h0000);
    Ret = 1'b1;
    tick;
    Ret = 1'b0;
    chk("ret_pop", 16'({Push_Stack, Pop_Stack, Busy}), 16'h0003);
    tick;
    chk("ret_pc",    PC, 16'h0011);
    chk("ret_depth", 16'(Depth), 16'h0000);

    // Five nested calls: depth saturates, fifth sets Overflow.
    for (int i = 0; i < 5; i++) begin
      Call = 1'b1; Target = call_tgt[i];
      tick;
      Call = 1'b0;
      chk($sformatf("nest_bus%0d", i), w_bus, call_bus[i]);
      tick;
      chk($sformatf("nest_pc%0d", i), PC, call_tgt[i]);
      chk($sformatf("nest_depth%0d", i), 16'(Depth), 16'((i < 4) ? i + 1 : 4));
      chk($sformatf("nest_ovf%0d", i), 16'(Overflow), 16'((i == 4) ? 1 : 0));
    end

    // Five returns: the oldest return address was lost, the last pop is empty.
    for (int i = 0; i < 5; i++) begin
      Ret = 1'b1;
      tick;
      Ret = 1'b0;
      tick;
      chk($sformatf("unw_pc%0d", i), PC, ret_pc[i]);
      chk($sformatf("unw_depth%0d", i), 16'(Depth), 16'((i < 4) ? 3 - i : 0));
      chk($sformatf("unw_udf%0d", i), 16'(Underflow), 16'((i == 4) ? 1 : 0));
    end

    // Interrupt beats a simultaneous call, then Reti.
    set_pc(16'h0050);
    Irq = 1'b1; Call = 1'b1; Target = 16'h0300;
    tick;
    Call = 1'b0;
    chk("irq_push", 16'(Push_Stack), 16'h0001);
    chk("irq_bus",  w_bus, 16'h0050);
    chk("irq_act",  16'(Int_Active), 16'h0001);
    tick;
    chk("irq_pc",    PC, 16'h0004);
    chk("irq_depth", 16'(Depth), 16'h0001);
    tick;
    chk("irq_held_pc",   PC, 16'h0004);
    chk("irq_held_strb", 16'({Push_Stack, Busy}), 16'h0000);
    chk("irq_held_depth", 16'(Depth), 16'h0001);
    Irq = 1'b0;
    Reti = 1'b1;
    tick;
    Reti = 1'b0;
    chk("reti_pop", 16'(Pop_Stack), 16'h0001);
    chk("reti_act_during", 16'(Int_Active), 16'h0001);
    tick;
    chk("reti_pc",  PC, 16'h0050);
    chk("reti_act", 16'(Int_Active), 16'h0000);
    chk("reti_depth", 16'(Depth), 16'h0000);

    // PC wrap and call at the top of the address space.
    set_pc(16'hFFFF);
    PC_Inc = 1'b1;
    tick;
    PC_Inc = 1'b0;
    chk("inc_wrap", PC, 16'h0000);
    set_pc(16'hFFFF);
    Call = 1'b1; Target = 16'h0700;
    tick;
    chk("wrap_bus", w_bus, 16'h0000);

    // Commands presented while PUSH is in progress are ignored.
    Call = 1'b1; Jump = 1'b1; PC_Inc = 1'b1; Target = 16'h0900;
    tick;
    Call = 1'b0; Jump = 1'b0; PC_Inc = 1'b0;
    chk("busy_pc",   PC, 16'h0700);
    chk("busy_idle", 16'(Push_Stack), 16'h0000);
    tick;
    chk("busy_pc2",   PC, 16'h0700);
    chk("busy_depth", 16'(Depth), 16'h0001);
    chk("sticky",     16'({Overflow, Underflow}), 16'h0003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
